// File: rtl/if_stage_mo_if.sv
// inst_sram-like request/response bus between the fetch stage and instruction memory.
interface if_stage_mo_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/if_stage_mo.sv
// Multi-outstanding instruction fetch stage: in-flight PC FIFO, instruction queue
// ahead of decode, and a discard counter that drops responses made stale by redirects.
module if_stage_mo #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IQ_DEPTH        = 4,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ds_allowin,
  output logic          fs_to_ds_valid,
  output logic [31:0]   fs_inst,
  output logic [31:0]   fs_pc,
  output logic          fs_adef_ex,
  input  logic          br_stall,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          wb_ex,
  input  logic [31:0]   ex_entry,
  input  logic          ertn_flush,
  input  logic [31:0]   ertn_entry,
  if_stage_mo_if.master inst_sram
);

  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DCW = $clog2(2 * MAX_OUTSTANDING + 1);
  localparam int unsigned OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IPW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int unsigned ICW = $clog2(IQ_DEPTH + 1);
  localparam int unsigned SW  = ((ICW > OCW) ? ICW : OCW) + 1;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  logic [31:0]    pf_pc;
  logic [31:0]    pc_fifo [MAX_OUTSTANDING];
  logic [OPW-1:0] op_wr, op_rd;
  logic [OCW-1:0] out_cnt;
  logic [DCW-1:0] discard_cnt;
  iq_entry_t      iq_mem [IQ_DEPTH];
  logic [IPW-1:0] iq_wr, iq_rd;
  logic [ICW-1:0] iq_cnt;
  logic           adef_hold;

  logic           redirect;
  logic [31:0]    target;
  logic [SW-1:0]  occ;
  logic           issue;
  logic           hs;
  logic           resp;
  logic           resp_keep;
  logic           adef_push;
  logic           iq_push;
  logic           pop;
  iq_entry_t      push_entry;
  iq_entry_t      head;
  logic [DCW-1:0] disc_redirect;

  function automatic logic [OPW-1:0] op_inc(input logic [OPW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + OPW'(1);
  endfunction

  function automatic logic [IPW-1:0] iq_inc(input logic [IPW-1:0] p);
    return (32'(p) == IQ_DEPTH - 1) ? '0 : p + IPW'(1);
  endfunction

  assign redirect = wb_ex | ertn_flush | br_taken;
  assign target   = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
  assign occ      = SW'(iq_cnt) + SW'(out_cnt);

  // Issue only when every outstanding response is guaranteed an IQ slot.
  assign issue = resetn & ~redirect & ~br_stall & ~adef_hold
               & (pf_pc[1:0] == 2'b00)
               & (out_cnt < OCW'(MAX_OUTSTANDING))
               & (occ < SW'(IQ_DEPTH));
  assign hs        = issue & inst_sram.inst_sram_addr_ok;
  assign resp      = inst_sram.inst_sram_data_ok;
  assign resp_keep = resp & (discard_cnt == '0);

  assign adef_push = resetn & ~redirect & ~adef_hold
                   & (pf_pc[1:0] != 2'b00)
                   & (out_cnt == '0) & (discard_cnt == '0)
                   & (iq_cnt < ICW'(IQ_DEPTH));
  assign iq_push   = resetn & ~redirect & (resp_keep | adef_push);
  assign push_entry = adef_push ? iq_entry_t'{adef: 1'b1, pc: pf_pc, inst: 32'h0}
                                : iq_entry_t'{adef: 1'b0, pc: pc_fifo[op_rd],
                                              inst: inst_sram.inst_sram_rdata};

  assign head           = iq_mem[iq_rd];
  assign fs_to_ds_valid = (iq_cnt != '0);
  assign fs_inst        = fs_to_ds_valid ? head.inst : 32'h0;
  assign fs_pc          = fs_to_ds_valid ? head.pc   : 32'h0;
  assign fs_adef_ex     = fs_to_ds_valid & head.adef;
  assign pop            = fs_to_ds_valid & ds_allowin;

  // Every live request becomes stale on redirect; a same-cycle response retires one of them.
  assign disc_redirect = discard_cnt + DCW'(out_cnt) - DCW'(resp);

  assign inst_sram.inst_sram_req   = issue;
  assign inst_sram.inst_sram_wr    = 1'b0;
  assign inst_sram.inst_sram_size  = 2'b10;
  assign inst_sram.inst_sram_wstrb = 4'h0;
  assign inst_sram.inst_sram_addr  = pf_pc;
  assign inst_sram.inst_sram_wdata = 32'h0;

  // Control state: pointers, counters and fetch PC.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc       <= RESET_PC;
      op_wr       <= '0;
      op_rd       <= '0;
      out_cnt     <= '0;
      discard_cnt <= '0;
      iq_wr       <= '0;
      iq_rd       <= '0;
      iq_cnt      <= '0;
      adef_hold   <= 1'b0;
    end else if (redirect) begin
      pf_pc       <= target;
      op_wr       <= '0;
      op_rd       <= '0;
      out_cnt     <= '0;
      discard_cnt <= disc_redirect;
      iq_wr       <= '0;
      iq_rd       <= '0;
      iq_cnt      <= '0;
      adef_hold   <= 1'b0;
    end else begin
      if (hs) begin
        pf_pc <= pf_pc + 32'd4;
        op_wr <= op_inc(op_wr);
      end
      if (resp_keep) begin
        op_rd <= op_inc(op_rd);
      end else if (resp) begin
        discard_cnt <= discard_cnt - DCW'(1);
      end
      out_cnt <= out_cnt + OCW'(hs) - OCW'(resp_keep);
      if (iq_push) begin
        iq_wr <= iq_inc(iq_wr);
      end
      if (pop) begin
        iq_rd <= iq_inc(iq_rd);
      end
      iq_cnt <= iq_cnt + ICW'(iq_push) - ICW'(pop);
      if (adef_push) begin
        adef_hold <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; occupancy counters qualify their contents.
  always_ff @(posedge clk) begin
    if (hs) begin
      pc_fifo[op_wr] <= pf_pc;
    end
    if (iq_push) begin
      iq_mem[iq_wr] <= push_entry;
    end
  end

endmodule

// File: tb/tb_if_stage_mo.sv
// Directed bench for if_stage_mo: queue-based reference model checked every cycle,
// plus hand-computed fetch/pop sequences for each scenario.
module tb_if_stage_mo;
  localparam int unsigned MAXO = 2;
  localparam int unsigned IQD  = 4;
  localparam logic [31:0] RPC  = 32'h1c000000;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, ds_allowin, br_stall, br_taken, wb_ex, ertn_flush;
  logic [31:0] br_target, ex_entry, ertn_entry;
  logic        fs_to_ds_valid, fs_adef_ex;
  logic [31:0] fs_inst, fs_pc;

  if_stage_mo_if sram();

  if_stage_mo #(.MAX_OUTSTANDING(MAXO), .IQ_DEPTH(IQD), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .fs_adef_ex(fs_adef_ex), .br_stall(br_stall), .br_taken(br_taken),
    .br_target(br_target), .wb_ex(wb_ex), .ex_entry(ex_entry),
    .ertn_flush(ertn_flush), .ertn_entry(ertn_entry), .inst_sram(sram.master)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          addr_ok_en, resp_en;
  logic [31:0] pend[$];
  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];
  int          gaps;
  bit          seen_valid;

  // Reference model state
  bit          m_live;
  logic [31:0] m_pf;
  logic [31:0] m_fl[$];
  ent_t        m_iq[$];
  int          m_disc;
  bit          m_hold;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hdeadbeef;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive SRAM response, compare against the model, advance everything.
  task automatic tick();
    logic [31:0] tgt, pc;
    bit          redir, mr, misal, dok;
    int          fl_n, iq_n;
    sram.inst_sram_addr_ok = addr_ok_en;
    dok = resp_en && (pend.size() > 0) && resetn;
    sram.inst_sram_data_ok = dok;
    sram.inst_sram_rdata   = dok ? inst_of(pend[0]) : 32'h0;
    #1;
    redir = wb_ex | ertn_flush | br_taken;
    tgt   = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    fl_n  = m_fl.size();
    iq_n  = m_iq.size();
    mr = resetn && !redir && !br_stall && !m_hold && (m_pf[1:0] == 2'b00)
         && (fl_n < MAXO) && (iq_n + fl_n < IQD);
    if (m_live) begin
      chk("req", 32'(sram.inst_sram_req), 32'(mr));
      chk("addr", sram.inst_sram_addr, m_pf);
      chk("valid", 32'(fs_to_ds_valid), 32'(iq_n != 0));
      if (iq_n != 0) begin
        chk("head_pc", fs_pc, m_iq[0].pc);
        chk("head_inst", fs_inst, m_iq[0].inst);
        chk("head_adef", 32'(fs_adef_ex), 32'(m_iq[0].adef));
      end
    end
    if (sram.inst_sram_req && addr_ok_en) hs_log.push_back(sram.inst_sram_addr);
    if (fs_to_ds_valid && ds_allowin) pop_log.push_back(fs_pc);
    if (seen_valid && !fs_to_ds_valid) gaps++;
    if (fs_to_ds_valid) seen_valid = 1'b1;
    if (!resetn) begin
      pend.delete();
    end else begin
      if (dok) void'(pend.pop_front());
      if (sram.inst_sram_req && addr_ok_en) pend.push_back(sram.inst_sram_addr);
    end
    if (!resetn) begin
      m_pf = RPC; m_fl.delete(); m_iq.delete(); m_disc = 0; m_hold = 1'b0; m_live = 1'b1;
    end else begin
      misal = (m_pf[1:0] != 2'b00) && (fl_n == 0) && (m_disc == 0) && (iq_n < IQD) && !m_hold;
      if (redir) begin
        if (dok) begin
          if (m_disc > 0) m_disc--;
          else if (m_fl.size() > 0) void'(m_fl.pop_front());
        end
        m_disc += m_fl.size();
        m_fl.delete(); m_iq.delete(); m_pf = tgt; m_hold = 1'b0;
      end else begin
        if (iq_n > 0 && ds_allowin) void'(m_iq.pop_front());
        if (dok) begin
          if (m_disc > 0) m_disc--;
          else if (m_fl.size() > 0) begin
            pc = m_fl.pop_front();
            m_iq.push_back({1'b0, pc, inst_of(pc)});
          end
        end
        if (misal) begin
          m_iq.push_back({1'b1, m_pf, 32'h0});
          m_hold = 1'b1;
        end
        if (mr && addr_ok_en) begin
          m_fl.push_back(m_pf);
          m_pf = m_pf + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    hs_log.delete(); pop_log.delete(); gaps = 0; seen_valid = 1'b0;
  endtask

  task automatic rst_seq(input int n);
    resetn = 1'b0; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0;
    wb_ex = 1'b0; ertn_flush = 1'b0; addr_ok_en = 1'b1; resp_en = 1'b1;
    repeat (n) tick();
    chk("rst_req", 32'(sram.inst_sram_req), 32'd0);
    chk("rst_addr", sram.inst_sram_addr, RPC);
    chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
    resetn = 1'b1;
    clear_logs();
  endtask

  initial begin
    resetn = 1'b0; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0;
    wb_ex = 1'b0; ertn_flush = 1'b0; br_target = 32'h0; ex_entry = 32'h0;
    ertn_entry = 32'h0; addr_ok_en = 1'b1; resp_en = 1'b1; m_live = 1'b0;
    m_pf = RPC; m_disc = 0; m_hold = 1'b0;
    sram.inst_sram_addr_ok = 1'b0; sram.inst_sram_data_ok = 1'b0; sram.inst_sram_rdata = 32'h0;
    @(negedge clk);

    // Reset values
    rst_seq(2);
    chk("rst_inst", fs_inst, 32'h0);
    chk("rst_pc", fs_pc, 32'h0);
    chk("rst_adef", 32'(fs_adef_ex), 32'd0);
    chk("const_wr", 32'(sram.inst_sram_wr), 32'd0);
    chk("const_size", 32'(sram.inst_sram_size), 32'd2);
    chk("const_wstrb", 32'(sram.inst_sram_wstrb), 32'd0);
    chk("const_wdata", sram.inst_sram_wdata, 32'd0);

    // Streaming: back-to-back fetch and gapless output
    repeat (12) tick();
    chk("t1_hs0", qget(hs_log, 0), 32'h1c000000);
    chk("t1_hs1", qget(hs_log, 1), 32'h1c000004);
    chk("t1_hs2", qget(hs_log, 2), 32'h1c000008);
    chk("t1_pop0", qget(pop_log, 0), 32'h1c000000);
    chk("t1_pop1", qget(pop_log, 1), 32'h1c000004);
    chk("t1_pop2", qget(pop_log, 2), 32'h1c000008);
    chk("t1_npop", 32'(pop_log.size()), 32'd10);
    chk("t1_gaps", 32'(gaps), 32'd0);

    // Decode stalled: IQ fills to depth, issue stops
    rst_seq(1);
    ds_allowin = 1'b0;
    repeat (10) tick();
    chk("t2_nhs", 32'(hs_log.size()), 32'd4);
    chk("t2_req", 32'(sram.inst_sram_req), 32'd0);
    chk("t2_valid", 32'(fs_to_ds_valid), 32'd1);
    ds_allowin = 1'b1;
    repeat (6) tick();
    chk("t2_pop0", qget(pop_log, 0), 32'h1c000000);
    chk("t2_pop1", qget(pop_log, 1), 32'h1c000004);
    chk("t2_pop2", qget(pop_log, 2), 32'h1c000008);
    chk("t2_pop3", qget(pop_log, 3), 32'h1c00000c);

    // Branch with two requests in flight: both responses dropped
    rst_seq(1);
    resp_en = 1'b0;
    repeat (2) tick();
    chk("t3_nhs", 32'(hs_log.size()), 32'd2);
    chk("t3_req_full", 32'(sram.inst_sram_req), 32'd0);
    clear_logs();
    br_taken = 1'b1; br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0; resp_en = 1'b1;
    repeat (8) tick();
    chk("t3_hs0", qget(hs_log, 0), 32'h1c000100);
    chk("t3_pop0", qget(pop_log, 0), 32'h1c000100);

    // wb_ex beats br_taken; same-cycle response consumes one stale request
    rst_seq(1);
    resp_en = 1'b0;
    repeat (2) tick();
    resp_en = 1'b1;
    wb_ex = 1'b1; ex_entry = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000100;
    clear_logs();
    tick();
    wb_ex = 1'b0; br_taken = 1'b0;
    chk("t4_discard", 32'(dut.discard_cnt), 32'd1);
    repeat (6) tick();
    chk("t4_hs0", qget(hs_log, 0), 32'h1c008000);
    chk("t4_pop0", qget(pop_log, 0), 32'h1c008000);

    // Misaligned target: one adef entry, issue frozen until exception redirect
    rst_seq(1);
    ds_allowin = 1'b0;
    br_taken = 1'b1; br_target = 32'h1c000102;
    tick();
    br_taken = 1'b0;
    repeat (4) tick();
    chk("t5_nhs", 32'(hs_log.size()), 32'd0);
    chk("t5_valid", 32'(fs_to_ds_valid), 32'd1);
    chk("t5_adef", 32'(fs_adef_ex), 32'd1);
    chk("t5_pc", fs_pc, 32'h1c000102);
    chk("t5_inst", fs_inst, 32'h0);
    ds_allowin = 1'b1;
    repeat (3) tick();
    chk("t5_npop", 32'(pop_log.size()), 32'd1);
    chk("t5_req", 32'(sram.inst_sram_req), 32'd0);
    wb_ex = 1'b1; ex_entry = 32'h1c008000;
    clear_logs();
    tick();
    wb_ex = 1'b0;
    repeat (4) tick();
    chk("t5_hs0", qget(hs_log, 0), 32'h1c008000);

    // Reset mid-operation with two requests outstanding and a non-empty IQ
    rst_seq(1);
    ds_allowin = 1'b0;
    repeat (3) tick();
    resp_en = 1'b0;
    tick();
    chk("t6_pend", 32'(pend.size()), 32'd2);
    chk("t6_valid_pre", 32'(fs_to_ds_valid), 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1; resp_en = 1'b1; ds_allowin = 1'b1;
    chk("t6_valid", 32'(fs_to_ds_valid), 32'd0);
    chk("t6_addr", sram.inst_sram_addr, RPC);
    repeat (3) tick();

    // Address wrap and br_stall
    rst_seq(1);
    br_taken = 1'b1; br_target = 32'hfffffffc;
    tick();
    br_taken = 1'b0;
    repeat (3) tick();
    chk("t7_hs0", qget(hs_log, 0), 32'hfffffffc);
    chk("t7_hs1", qget(hs_log, 1), 32'h00000000);
    chk("t7_pop0", qget(pop_log, 0), 32'hfffffffc);
    br_stall = 1'b1;
    hs_log.delete();
    repeat (3) tick();
    chk("t7_stall_nhs", 32'(hs_log.size()), 32'd0);
    chk("t7_pop1", qget(pop_log, 1), 32'h00000000);
    br_stall = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
